if_stage: RTL and testbench

Instruction-fetch stage of the RV64I five-stage pipeline. Owns the fetch PC, drives the 64-bit synchronous instruction SRAM port and extracts the 32-bit instruction word from the returned doubleword. Holds its output across decode stalls with a one-entry buffer and applies branch/jump redirects from EX. Feeds the ID stage through a registered-valid IF→ID bus.

---
 rtl/if_stage.sv | 117 +++++++++++
 tb/tb_if_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: RV64I instruction-fetch stage.
// Owns the fetch PC, drives the 64-bit synchronous instruction SRAM and
// extracts the addressed 32-bit word. A one-entry buffer keeps the output
// stable across decode stalls. EX redirects take priority over stalls.
// Optional feature macro: IF_MISALIGN_EXC_EN. When defined, a redirect to
// a target that is not 4-byte aligned raises a fetch exception entry and
// halts fetching until the next redirect.
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          IF2ID_WD = 97
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic [63:0]         flush_pc_i,
  output logic                inst_sram_en,
  output logic [7:0]          inst_sram_we,
  output logic [63:0]         inst_sram_addr,
  output logic [63:0]         inst_sram_wdata,
  input  logic [63:0]         inst_sram_rdata,
  output logic                if2id_valid,
  output logic [IF2ID_WD-1:0] if2id_bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        run;
  logic [63:0] fetch_pc;
  logic        resp_vld;
  logic [63:0] resp_pc;
  logic        resp_exc;
  logic        hold_vld;
  logic [31:0] hold_inst;
  logic        halt;
  logic        misalign;
  logic [63:0] flush_tgt;
  logic [31:0] sel_inst;
  logic [31:0] out_inst;

`ifdef IF_MISALIGN_EXC_EN
  assign misalign  = |flush_pc_i[1:0];
  assign flush_tgt = flush_pc_i;

  // Halt latch: a misaligned redirect stops fetching until the next redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          halt <= 1'b0;
    else if (flush_i) halt <= misalign;
  end
`else
  // Low target bits are dropped, so a misaligned redirect fetches the
  // enclosing aligned word.
  assign misalign  = 1'b0;
  assign flush_tgt = flush_pc_i & ~64'h3;
  assign halt      = 1'b0;
`endif

  assign inst_sram_en    = run & ~stall_i & ~flush_i & ~halt;
  assign inst_sram_we    = 8'h00;
  assign inst_sram_wdata = 64'h0;
  assign inst_sram_addr  = {fetch_pc[63:3], 3'b000};

  // Word select from the returned doubleword; exception entries carry a NOP
  always_comb begin
    sel_inst = resp_pc[2] ? inst_sram_rdata[63:32] : inst_sram_rdata[31:0];
    if (resp_exc) sel_inst = NOP;
    out_inst = 32'h0;
    if (hold_vld)      out_inst = hold_inst;
    else if (resp_vld) out_inst = sel_inst;
  end

  // resp_pc/resp_exc are frozen during a stall, so they stay on the bus
  // directly; only the instruction word needs the hold buffer because the
  // SRAM output is not guaranteed to persist.
  assign if2id_valid = (hold_vld | resp_vld) & ~flush_i;
  assign if2id_bus   = {resp_exc, out_inst, resp_pc};

  // Fetch PC, response tracking and stall buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run       <= 1'b0;
      fetch_pc  <= RESET_PC;
      resp_vld  <= 1'b0;
      resp_pc   <= 64'h0;
      resp_exc  <= 1'b0;
      hold_vld  <= 1'b0;
      hold_inst <= 32'h0;
    end else begin
      run <= 1'b1;
      if (flush_i) begin
        // Redirect drops everything in flight; a misaligned target becomes
        // a single exception entry presented next cycle.
        fetch_pc <= flush_tgt;
        resp_pc  <= flush_tgt;
        resp_vld <= misalign;
        resp_exc <= misalign;
        hold_vld <= 1'b0;
      end else if (stall_i) begin
        if (!hold_vld) begin
          hold_inst <= sel_inst;
          hold_vld  <= resp_vld;
        end
      end else begin
        // Release edge: ID consumes the current output while the next
        // request is already in flight, so no bubble and no duplicate.
        hold_vld <= 1'b0;
        resp_vld <= inst_sram_en;
        resp_exc <= 1'b0;
        if (inst_sram_en) begin
          resp_pc  <= fetch_pc;
          fetch_pc <= fetch_pc + 64'd4;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed test of the fetch stage against a small SRAM model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [63:0] flush_pc_i;
  logic        inst_sram_en;
  logic [7:0]  inst_sram_we;
  logic [63:0] inst_sram_addr;
  logic [63:0] inst_sram_wdata;
  logic [63:0] inst_sram_rdata = 64'h0;
  logic        if2id_valid;
  logic [96:0] if2id_bus;

  int checks = 0;
  int failures = 0;

  if_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .flush_pc_i(flush_pc_i), .inst_sram_en(inst_sram_en),
    .inst_sram_we(inst_sram_we), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_rdata(inst_sram_rdata),
    .if2id_valid(if2id_valid), .if2id_bus(if2id_bus)
  );

  always #5 clk = ~clk;

  // Doubleword contents at an 8-byte aligned address
  function automatic logic [63:0] mem(input logic [63:0] a);
    logic [31:0] lo;
    if (a == 64'h8000_0000) return 64'h00A00093_00500113;
    lo = a[31:0] ^ 32'h5A5A_0000;
    return {lo + 32'd4, lo};
  endfunction

  function automatic logic [31:0] word(input logic [63:0] pc);
    logic [63:0] d;
    d = mem({pc[63:3], 3'b000});
    return pc[2] ? d[63:32] : d[31:0];
  endfunction

  // Synchronous SRAM; output turns to garbage on idle cycles
  always @(posedge clk)
    inst_sram_rdata <= inst_sram_en ? mem(inst_sram_addr) : 64'hDEAD_BEEF_DEAD_BEEF;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic out(input string tag, input logic [63:0] pc, input logic exc);
    chk({tag, ".valid"}, 128'(if2id_valid), 128'(1'b1));
    chk({tag, ".pc"}, 128'(if2id_bus[63:0]), 128'(pc));
    chk({tag, ".inst"}, 128'(if2id_bus[95:64]), 128'(exc ? 32'h13 : word(pc)));
    chk({tag, ".exc"}, 128'(if2id_bus[96]), 128'(exc));
  endtask

  task automatic req(input string tag, input logic en, input logic [63:0] addr);
    chk({tag, ".en"}, 128'(inst_sram_en), 128'(en));
    if (en) chk({tag, ".addr"}, 128'(inst_sram_addr), 128'(addr));
  endtask

  logic [96:0] held;

  initial begin
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = 64'h0;
    #3;
    chk("rst.en", 128'(inst_sram_en), 128'(1'b0));
    chk("rst.we", 128'(inst_sram_we), 128'(8'h0));
    chk("rst.wdata", 128'(inst_sram_wdata), 128'(64'h0));
    chk("rst.addr", 128'(inst_sram_addr), 128'(64'h8000_0000));
    chk("rst.valid", 128'(if2id_valid), 128'(1'b0));
    chk("rst.bus", 128'(if2id_bus), 128'(97'h0));
    tick(); tick();
    rst = 1'b0;
    // cycle 1 after release
    #1 req("c1", 1'b0, 64'h0);
    tick(); req("c2", 1'b1, 64'h8000_0000);
    chk("c2.valid", 128'(if2id_valid), 128'(1'b0));
    tick(); req("c3", 1'b1, 64'h8000_0000);
    out("c3", 64'h8000_0000, 1'b0);
    chk("c3.inst_lit", 128'(if2id_bus[95:64]), 128'(32'h00500113));
    tick(); out("c4", 64'h8000_0004, 1'b0);
    chk("c4.inst_lit", 128'(if2id_bus[95:64]), 128'(32'h00A00093));
    tick(); out("c5", 64'h8000_0008, 1'b0);
    // stall for three cycles with pc 0x80000008 on the bus
    stall_i = 1'b1;
    #1 held = if2id_bus;
    req("st0", 1'b0, 64'h0);
    for (int i = 1; i < 3; i++) begin
      tick();
      req("st", 1'b0, 64'h0);
      chk("st.bus", 128'(if2id_bus), 128'(held));
      out("st", 64'h8000_0008, 1'b0);
    end
    tick(); stall_i = 1'b0;
    #1 req("rel", 1'b1, 64'h8000_0008);
    out("rel", 64'h8000_0008, 1'b0);
    tick(); out("rel+1", 64'h8000_000C, 1'b0);
    tick(); out("rel+2", 64'h8000_0010, 1'b0);
    // redirect
    flush_i = 1'b1; flush_pc_i = 64'h8000_1000;
    #1 chk("fl.N.valid", 128'(if2id_valid), 128'(1'b0));
    req("fl.N", 1'b0, 64'h0);
    tick(); flush_i = 1'b0;
    #1 chk("fl.N1.valid", 128'(if2id_valid), 128'(1'b0));
    req("fl.N1", 1'b1, 64'h8000_1000);
    tick(); out("fl.N2", 64'h8000_1000, 1'b0);
    tick(); out("fl.N3", 64'h8000_1004, 1'b0);
    // stall to fill the hold buffer, then flush while stalled
    stall_i = 1'b1;
    tick(); out("fs.hold", 64'h8000_1004, 1'b0);
    flush_i = 1'b1; flush_pc_i = 64'h8000_2000;
    #1 chk("fs.N.valid", 128'(if2id_valid), 128'(1'b0));
    tick(); flush_i = 1'b0; stall_i = 1'b0;
    #1 chk("fs.N1.valid", 128'(if2id_valid), 128'(1'b0));
    req("fs.N1", 1'b1, 64'h8000_2000);
    tick(); out("fs.N2", 64'h8000_2000, 1'b0);
    // misaligned redirect
    flush_i = 1'b1; flush_pc_i = 64'h8000_1002;
    tick(); flush_i = 1'b0;
`ifdef IF_MISALIGN_EXC_EN
    #1 req("mis.N1", 1'b0, 64'h0);
    out("mis.N1", 64'h8000_1002, 1'b1);
    tick(); req("mis.N2", 1'b0, 64'h0);
    chk("mis.N2.valid", 128'(if2id_valid), 128'(1'b0));
    tick(); req("mis.N3", 1'b0, 64'h0);
    flush_i = 1'b1; flush_pc_i = 64'h8000_3000;
    tick(); flush_i = 1'b0;
    #1 req("mis.re", 1'b1, 64'h8000_3000);
    tick(); out("mis.re", 64'h8000_3000, 1'b0);
`else
    #1 req("mis.N1", 1'b1, 64'h8000_1000);
    chk("mis.N1.valid", 128'(if2id_valid), 128'(1'b0));
    tick(); out("mis.N2", 64'h8000_1000, 1'b0);
`endif
    // reset in the middle of a stall: outputs clear with no clock edge
    stall_i = 1'b1;
    tick(); tick();
    rst = 1'b1;
    #1 chk("amid.en", 128'(inst_sram_en), 128'(1'b0));
    chk("amid.valid", 128'(if2id_valid), 128'(1'b0));
    chk("amid.bus", 128'(if2id_bus), 128'(97'h0));
    tick();
    rst = 1'b0; stall_i = 1'b0;
    #1 req("rr.c1", 1'b0, 64'h0);
    tick(); req("rr.c2", 1'b1, 64'h8000_0000);
    tick(); out("rr.c3", 64'h8000_0000, 1'b0);
    tick(); out("rr.c4", 64'h8000_0004, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
